seg_scan_decoder: RTL and testbench



---
 rtl/seg_scan_decoder.sv | 122 ++++++++++++
 tb/tb_seg_scan_decoder.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers hex nibbles from a multiplexed active-low 7-segment display bus.
// Optional SEG_DEC_ERR_CNT_EN enables the saturating pattern-error counter on err_count.
module seg_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   digit_blank,
  output logic                    frame_done,
  output logic                    pat_err,
  output logic [7:0]              err_count
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, TRACK, CAPTURED} state_t;
  state_t                  r_state, w_state_nxt;
  logic [CW-1:0]           r_cnt, w_cnt_nxt;
  logic [6:0]              r_seg_q, r_ref_seg;
  logic [NUM_DIGITS-1:0]   r_an_q, r_ref_an, r_seen, w_seen_nxt;
  logic [4*NUM_DIGITS-1:0] r_digits;
  logic [NUM_DIGITS-1:0]   r_valid, r_blank;
  logic                    r_frame, r_perr;
  logic                    w_onehot, w_same, w_load, w_cap, w_blank, w_hit, w_err;
  logic [3:0]              w_nib;
  assign w_onehot = $onehot(~r_an_q);
  assign w_same   = {r_an_q, r_seg_q} == {r_ref_an, r_ref_seg};
  assign w_blank  = r_ref_seg == 7'h7F;
  always_comb begin
    w_hit = 1'b1;
    w_nib = 4'h0;
    case (r_ref_seg)
      7'b1000000: w_nib = 4'h0;
      7'b1111001: w_nib = 4'h1;
      7'b0100100: w_nib = 4'h2;
      7'b0110000: w_nib = 4'h3;
      7'b0011001: w_nib = 4'h4;
      7'b0010010: w_nib = 4'h5;
      7'b0000010: w_nib = 4'h6;
      7'b1111000: w_nib = 4'h7;
      7'b0000000: w_nib = 4'h8;
      7'b0011000: w_nib = 4'h9;
      7'b0100000: w_nib = 4'hA;
      7'b0000011: w_nib = 4'hB;
      7'b0100111: w_nib = 4'hC;
      7'b0100001: w_nib = 4'hD;
      7'b0000100: w_nib = 4'hE;
      7'b0001110: w_nib = 4'hF;
      default:    w_hit = 1'b0;
    endcase
  end
  // Any pair change restarts tracking, so a change on the would-be capture cycle wins.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_cap       = 1'b0;
    if (r_state == IDLE || !w_same) begin
      w_state_nxt = w_onehot ? TRACK : IDLE;
      w_cnt_nxt   = w_onehot ? CW'(1) : '0;
      w_load      = w_onehot;
    end else if (r_state == TRACK) begin
      w_cnt_nxt   = r_cnt + 1'b1;
      w_cap       = r_cnt == CW'(STABLE_CYCLES - 1);
      w_state_nxt = w_cap ? CAPTURED : TRACK;
    end
  end
  assign w_seen_nxt = (w_cap && (w_blank || w_hit)) ? (r_seen | ~r_ref_an) : r_seen;
  assign w_err      = w_cap && !w_blank && !w_hit;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_q   <= 7'h7F;
      r_an_q    <= '1;
      r_ref_seg <= 7'h7F;
      r_ref_an  <= '1;
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_seen    <= '0;
      r_digits  <= '0;
      r_valid   <= '0;
      r_blank   <= '0;
      r_frame   <= 1'b0;
      r_perr    <= 1'b0;
    end else begin
      r_seg_q <= seg_n;
      r_an_q  <= an_n;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_load) begin
        r_ref_an  <= r_an_q;
        r_ref_seg <= r_seg_q;
      end
      r_frame <= &w_seen_nxt;
      r_perr  <= w_err;
      r_seen  <= (&w_seen_nxt) ? '0 : w_seen_nxt;
      for (int i = 0; i < NUM_DIGITS; i++)
        if (w_cap && !r_ref_an[i]) begin
          r_valid[i] <= w_hit;
          if (w_blank || w_hit) r_blank[i] <= w_blank;
          if (w_hit) r_digits[4*i +: 4] <= w_nib;
        end
    end
  end
  assign digits      = r_digits;
  assign digit_valid = r_valid;
  assign digit_blank = r_blank;
  assign frame_done  = r_frame;
  assign pat_err     = r_perr;
`ifdef SEG_DEC_ERR_CNT_EN
  logic [7:0] r_err_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err_cnt <= '0;
    else if (w_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
  end
  assign err_count = r_err_cnt;
`else
  assign err_count = 8'd0;
`endif
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: table-driven scan vectors with a latency-scheduled scoreboard.
module tb_seg_scan_decoder;
  localparam int ND = 4;
  localparam int SC = 4;
`ifdef SEG_DEC_ERR_CNT_EN
  localparam bit ECNT = 1'b1;
`else
  localparam bit ECNT = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg_n = 7'h7F;
  logic [3:0]  an_n = 4'hF;
  logic [15:0] digits;
  logic [3:0]  digit_valid, digit_blank;
  logic        frame_done, pat_err;
  logic [7:0]  err_count;
  seg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .seg_n(seg_n), .an_n(an_n), .digits(digits),
    .digit_valid(digit_valid), .digit_blank(digit_blank), .frame_done(frame_done),
    .pat_err(pat_err), .err_count(err_count)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0]  an;
    logic [6:0]  seg;
    int          hold;
    logic [15:0] d;
    logic [3:0]  v;
    logic [3:0]  b;
    logic        e;
    logic        f;
  } vec_t;
  typedef struct {
    int          due;
    int          id;
    logic [15:0] d;
    logic [3:0]  v;
    logic [3:0]  b;
    logic        e;
    logic        f;
    logic [7:0]  ec;
  } exp_t;
  vec_t tbl [13];
  exp_t q[$];
  exp_t cur;
  int cyc = 0, n_vec = 0, n_err = 0, n_frame = 0, n_perr = 0, m_err = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, id, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      n_frame <= n_frame + int'(frame_done);
      n_perr  <= n_perr + int'(pat_err);
    end
    if (q.size() > 0 && q[0].due == cyc) begin
      cur = q.pop_front();
      chk("digits", cur.id, 32'(digits), 32'(cur.d));
      chk("valid", cur.id, 32'(digit_valid), 32'(cur.v));
      chk("blank", cur.id, 32'(digit_blank), 32'(cur.b));
      chk("pat_err", cur.id, 32'(pat_err), 32'(cur.e));
      chk("frame_done", cur.id, 32'(frame_done), 32'(cur.f));
      chk("err_count", cur.id, 32'(err_count), 32'(cur.ec));
    end
  end
  task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int hold);
    an_n  = an;
    seg_n = seg;
    repeat (hold) @(posedge clk);
    #1;
  endtask
  task automatic apply(input int k);
    exp_t x;
    if (tbl[k].e && m_err < 255) m_err++;
    x.due = cyc + SC + 1;
    x.id  = k;
    x.d   = tbl[k].d;
    x.v   = tbl[k].v;
    x.b   = tbl[k].b;
    x.e   = tbl[k].e;
    x.f   = tbl[k].f;
    x.ec  = ECNT ? 8'(m_err) : 8'd0;
    q.push_back(x);
    drive(tbl[k].an, tbl[k].seg, tbl[k].hold);
  endtask
  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #1;
    chk("queue_drain", 0, 32'(q.size()), 32'd0);
  endtask
  task automatic chk_zero(input int id);
    chk("rst_digits", id, 32'(digits), 32'd0);
    chk("rst_valid", id, 32'(digit_valid), 32'd0);
    chk("rst_blank", id, 32'(digit_blank), 32'd0);
    chk("rst_frame", id, 32'(frame_done), 32'd0);
    chk("rst_pat_err", id, 32'(pat_err), 32'd0);
    chk("rst_err_count", id, 32'(err_count), 32'd0);
  endtask
  initial begin
    tbl[0]  = '{4'hE, 7'h30, 8, 16'h0003, 4'h1, 4'h0, 1'b0, 1'b0};
    tbl[1]  = '{4'hD, 7'h20, 8, 16'h00A3, 4'h3, 4'h0, 1'b0, 1'b0};
    tbl[2]  = '{4'hB, 7'h78, 8, 16'h07A3, 4'h7, 4'h0, 1'b0, 1'b0};
    tbl[3]  = '{4'h7, 7'h0E, 8, 16'hF7A3, 4'hF, 4'h0, 1'b0, 1'b1};
    tbl[4]  = '{4'hE, 7'h24, 3, 16'hF7A3, 4'hF, 4'h0, 1'b0, 1'b0};
    tbl[5]  = '{4'hB, 7'h7F, 6, 16'hF7A3, 4'hB, 4'h4, 1'b0, 1'b0};
    tbl[6]  = '{4'hE, 7'h55, 6, 16'hF7A3, 4'hA, 4'h4, 1'b1, 1'b0};
    tbl[7]  = '{4'h3, 7'h40, 10, 16'hF7A3, 4'hA, 4'h4, 1'b0, 1'b0};
    tbl[8]  = '{4'hE, 7'h40, 6, 16'hF7A0, 4'hB, 4'h4, 1'b0, 1'b0};
    tbl[9]  = '{4'hD, 7'h79, 6, 16'hF710, 4'hB, 4'h4, 1'b0, 1'b0};
    tbl[10] = '{4'h7, 7'h00, 6, 16'h8710, 4'hB, 4'h4, 1'b0, 1'b1};
    tbl[11] = '{4'hB, 7'h03, 8, 16'h8B10, 4'hF, 4'h0, 1'b0, 1'b0};
    tbl[12] = '{4'hD, 7'h27, 8, 16'h8BC0, 4'hF, 4'h0, 1'b0, 1'b0};
    repeat (3) @(posedge clk);
    #1;
    chk_zero(0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(4'hE, 7'h24, 3);
    drive(4'hF, 7'h7F, 6);
    chk("short_valid", 0, 32'(digit_valid), 32'd0);
    chk("short_digits", 0, 32'(digits), 32'd0);
    for (int k = 0; k < 13; k++) apply(k);
    drain();
    drive(4'hE, 7'h40, 2);
    #3;
    rst_n = 1'b0;
    #1;
    chk_zero(1);
    m_err = 0;
    an_n  = 4'hF;
    seg_n = 7'h7F;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) apply(k);
    drain();
    for (int i = 0; i < 300; i++) drive(i[0] ? 4'hD : 4'hE, 7'h55, 6);
    drive(4'hF, 7'h7F, 4);
    chk("sat_err_count", 0, 32'(err_count), ECNT ? 32'd255 : 32'd0);
    chk("pat_err_pulses", 0, 32'(n_perr), 32'd301);
    chk("frame_pulses", 0, 32'(n_frame), 32'd3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
